// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame size and default timing constants
package ps2_pkg;

    localparam int FRAME_BITS         = 11;
    localparam int DEF_CLK_FREQ_HZ    = 100_000_000;
    localparam int DEF_INHIBIT_CYCLES = 10_000;
    localparam int DEF_TIMEOUT_CYCLES = 1_700_000;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizers for both PS/2 lines plus a registered ps2_clk falling-edge strobe
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Synchronize to clk; flops idle high so reset never fakes an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            data_ff  <= {data_ff[0], ps2_data_in};
            clk_prev <= clk_ff[1];
            clk_fall <= clk_prev & ~clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter with open-drain clock/data drivers
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int INHIBIT_CYCLES = int'(longint'(DEF_INHIBIT_CYCLES) * CLK_FREQ_HZ / DEF_CLK_FREQ_HZ),
    parameter int TIMEOUT_CYCLES = int'(longint'(DEF_TIMEOUT_CYCLES) * CLK_FREQ_HZ / DEF_CLK_FREQ_HZ)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);

    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int EW = $clog2(FRAME_BITS) + 1;
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [EW-1:0] EDGE_PAR  = EW'(FRAME_BITS - 3);
    localparam logic [EW-1:0] EDGE_STOP = EW'(FRAME_BITS - 2);

    ps2_state_t    state, state_n;
    logic [7:0]    data_q, data_n;
    logic          par_q, par_n;
    logic [IW-1:0] inh_q, inh_n;
    logic [TW-1:0] to_q, to_n;
    logic [EW-1:0] edge_q, edge_n;
    logic          clk_oe, clk_oe_n;
    logic          data_oe, data_oe_n;
    logic          done_n, err_n;
    logic          clk_s, data_s, clk_fall;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk),
        .ps2_data_in(ps2_data),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall   (clk_fall)
    );

    assign ps2_clk    = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data   = data_oe ? 1'b0 : 1'bz;
    assign tx_ready   = state == IDLE;
    assign rx_inhibit = state != IDLE;

    // Frame sequencing; the timeout check runs last so it overrides any same-cycle edge
    always_comb begin
        state_n   = state;
        data_n    = data_q;
        par_n     = par_q;
        inh_n     = inh_q;
        to_n      = to_q;
        edge_n    = edge_q;
        clk_oe_n  = clk_oe;
        data_oe_n = data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    data_n   = tx_data;
                    par_n    = odd_parity(tx_data);
                    inh_n    = '0;
                    clk_oe_n = 1'b1;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    data_oe_n = 1'b1;
                    state_n   = RTS;
                end else begin
                    inh_n = inh_q + 1'b1;
                end
            end
            RTS: begin
                clk_oe_n = 1'b0;
                edge_n   = '0;
                to_n     = '0;
                state_n  = SHIFT;
            end
            SHIFT: begin
                if (clk_fall) begin
                    edge_n = edge_q + 1'b1;
                    if (edge_q == EDGE_STOP) begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = (edge_q == EDGE_PAR) ? ~par_q : ~data_q[edge_q[2:0]];
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    err_n   = data_s;
                    state_n = data_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state inside {SHIFT, ACK, WAIT_IDLE}) begin
            if (to_q == TO_LAST) begin
                state_n   = IDLE;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                done_n    = 1'b0;
                err_n     = 1'b1;
            end else begin
                to_n = to_q + 1'b1;
            end
        end
    end

    // State, counters, latched byte and line drivers; reset abandons any frame silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            data_q  <= '0;
            par_q   <= 1'b0;
            inh_q   <= '0;
            to_q    <= '0;
            edge_q  <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_n;
            data_q  <= data_n;
            par_q   <= par_n;
            inh_q   <= inh_n;
            to_q    <= to_n;
            edge_q  <= edge_n;
            clk_oe  <= clk_oe_n;
            data_oe <= data_oe_n;
            tx_done <= done_n;
            tx_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with a behavioural PS/2 device model
module tb_ps2_tx;

    localparam int INH = 100;
    localparam int TMO = 2000;
    localparam int H   = 20;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } frame_t;

    typedef struct {
        logic done;
        logic tmo;
    } resp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, rx_inhibit;
    logic       dev_clk = 1'b0;
    logic       dev_data = 1'b0;
    logic       abort_seen = 1'b0;
    int         dev_mode = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    frame_t     frame_q[$];
    resp_t      resp_q[$];

    wire ps2_clk;
    wire ps2_data;
    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data ? 1'b0 : 1'bz;

    ps2_tx #(
        .CLK_FREQ_HZ   (100_000_000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .rx_inhibit(rx_inhibit),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device: 10 clock pulses sampling on the low phase, then the ACK pulse
    task automatic dev_frame();
        logic [9:0] b;
        frame_t     f;
        b = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("start_bit", ps2_data, 0);
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b1;
            repeat (H) @(posedge clk);
            #1;
            b[k] = ps2_data;
            dev_clk = 1'b0;
            if (dev_mode == 3 && k == 4) begin
                abort_seen = 1'b1;
                return;
            end
            repeat (H) @(posedge clk);
            #1;
        end
        if (dev_mode == 0) dev_data = 1'b1;
        repeat (H / 2) @(posedge clk);
        #1;
        dev_clk = 1'b1;
        repeat (H) @(posedge clk);
        #1;
        dev_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dev_data = 1'b0;
        if (frame_q.size() == 0) begin
            chk("frame_unexpected", 1, 0);
        end else begin
            f = frame_q.pop_front();
            chk("frame_data", b[7:0], f.d);
            chk("frame_parity", b[8], f.p);
            chk("stop_bit", b[9], 1);
        end
    endtask

    initial begin
        int n;
        forever begin
            @(posedge clk);
            #1;
            if (!(ps2_clk === 1'b1 && ps2_data === 1'b0) || dev_mode == 2) continue;
            dev_frame();
            n = 0;
            while (ps2_data !== 1'b1 && n < TMO + 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
    end

    // Monitor: every completion pulse is matched against the next expected response
    initial begin
        logic  prev;
        int    last_rise;
        resp_t r;
        prev = 1'b1;
        last_rise = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ps2_clk === 1'b1 && prev !== 1'b1) last_rise = cyc;
            prev = ps2_clk;
            if (tx_done || tx_err) begin
                chk("pulse_exclusive", tx_done & tx_err, 0);
                if (resp_q.size() == 0) begin
                    chk("unexpected_pulse", {tx_done, tx_err}, 0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_done", tx_done, r.done);
                    chk("resp_err", tx_err, !r.done);
                    chk("ready_at_end", tx_ready, 1);
                    if (r.tmo) begin
                        chk("timeout_cycles", cyc - last_rise, TMO);
                        chk("timeout_lines", {ps2_clk, ps2_data}, 2'b11);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input int mode, input logic push_frame, input logic exp_p,
                        input logic push_resp, input logic r_done, input logic r_tmo);
        int n;
        dev_mode = mode;
        if (push_frame) frame_q.push_back('{d, exp_p});
        if (push_resp) resp_q.push_back('{r_done, r_tmo});
        n = 0;
        while (!tx_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk === 1'b0 && ps2_data === 1'b1 && n < INH + 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("inhibit_cycles", n, INH);
        chk("rts_lines", {ps2_clk, ps2_data}, 2'b00);
        @(posedge clk);
        #1;
        chk("clk_release", {ps2_clk, ps2_data}, 2'b10);
        chk("busy_flags", {tx_ready, rx_inhibit}, 2'b01);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || !tx_ready) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("completion_in_time", n < 20000, 1);
        repeat (3 * H) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {tx_ready, tx_done, tx_err, rx_inhibit}, 4'b1000);
        chk("reset_lines", {ps2_clk, ps2_data}, 2'b11);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", {tx_ready, rx_inhibit}, 2'b10);

        send(8'hED, 0, 1, 1'b1, 1, 1, 0);
        wait_done();
        send(8'h07, 0, 1, 1'b0, 1, 1, 0);
        wait_done();
        send(8'h00, 0, 1, 1'b1, 1, 1, 0);
        wait_done();

        send(8'hED, 0, 1, 1'b1, 1, 1, 0);
        repeat (100) @(posedge clk);
        #1;
        chk("busy_mid_transfer", tx_ready, 0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_done();

        send(8'hA5, 1, 1, 1'b1, 1, 0, 0);
        wait_done();

        send(8'h3C, 2, 0, 1'b0, 1, 0, 1);
        wait_done();

        send(8'hED, 3, 0, 1'b0, 0, 0, 0);
        n = 0;
        while (!abort_seen && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached", abort_seen, 1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("abort_lines", {ps2_clk, ps2_data}, 2'b11);
        chk("abort_outputs", {tx_ready, tx_done, tx_err, rx_inhibit}, 4'b1000);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        abort_seen = 1'b0;
        repeat (3 * H) @(posedge clk);
        #1;

        send(8'hF4, 0, 1, 1'b0, 1, 1, 0);
        wait_done();

        chk("queues_empty", frame_q.size() + resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
